// File: rtl/fpu_result_collector_if.sv
// Result stream from the collector FIFO head to a stallable consumer.
// master drives data/valid/class flags, slave returns ready.
interface fpu_result_collector_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_nan;
  logic        out_is_inf;

  modport master (
    output out_data,
    output out_valid,
    output out_is_nan,
    output out_is_inf,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_is_nan,
    input  out_is_inf,
    output out_ready
  );
endinterface

// File: rtl/fpu_result_collector.sv
// Reassembles two-beat FPU result frames into binary16 words and queues
// them in a FWFT FIFO.
//
// Ports:
//   clock, reset      rising-edge clock, sync active-high reset
//   res_byte/res_flag serial result byte and valid flag from the FPU
//   out (master)      FIFO head: data, valid, ready, nan/inf class
//   level             current FIFO occupancy (0..DEPTH)
//   overflow          sticky: a completed word was dropped while full
//   frame_err         one-cycle pulse after a frame was aborted
module fpu_result_collector #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               res_byte,
  input  logic                     res_flag,
  fpu_result_collector_if.master   out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    HIGH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]    lo_q;
  logic          lo_ld;
  logic          push;
  logic          abort;
  logic [15:0]   word_d;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt_q;
  logic          ovf_q;
  logic          err_q;

  logic          empty;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;
  logic [15:0]   head;
  logic [4:0]    head_exp;

  // Frame assembler. WAIT_LOW guarantees we never start
  // capturing in the middle of a frame.
  always_comb begin
    state_d = state_q;
    lo_ld   = 1'b0;
    push    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      WAIT_LOW: begin
        if (!res_flag) state_d = IDLE;
      end
      IDLE: begin
        if (res_flag) begin
          lo_ld   = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (res_flag) begin
          push    = 1'b1;
          state_d = WAIT_LOW;
        end else begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  assign word_d = {res_byte, lo_q};

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == LW'(DEPTH));
  assign pop   = !empty && out.out_ready;

  // A push into a full FIFO only lands if the head
  // leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_LOW;
      lo_q    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (lo_ld) lo_q <= res_byte;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + LW'(1);
        2'b01:   cnt_q <= cnt_q - LW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop) ovf_q <= 1'b1;
      err_q <= abort;
    end
  end

  // Storage carries no reset; the head is masked
  // while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= word_d;
  end

  assign head     = mem[rd_ptr];
  assign head_exp = head[14:10];

  assign out.out_valid  = !empty;
  assign out.out_data   = empty ? 16'h0000 : head;
  assign out.out_is_nan = !empty && (&head_exp) && (|head[9:0]);
  assign out.out_is_inf = !empty && (&head_exp) && !(|head[9:0]);

  assign level     = cnt_q;
  assign overflow  = ovf_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Self-checking bench for fpu_result_collector: vector table, scoreboard
// on the output stream, and directed overflow/abort/reset sequences.
module tb_fpu_result_collector;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] res_byte;
  logic       res_flag;
  logic [2:0] level;
  logic       overflow;
  logic       frame_err;

  fpu_result_collector_if bus ();

  fpu_result_collector #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .res_byte  (res_byte),
    .res_flag  (res_flag),
    .out       (bus),
    .level     (level),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] word;
    logic        nan;
    logic        inf;
  } vec_t;

  typedef struct {
    logic [15:0] w;
    logic        nan;
    logic        inf;
  } exp_t;

  vec_t tbl [7];
  exp_t sb [$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_word(input logic [15:0] w,
                             input logic nan,
                             input logic inf);
    exp_t e;
    e.w = w;
    e.nan = nan;
    e.inf = inf;
    sb.push_back(e);
  endtask

  // Leaves the caller in cycle L+2 with res_flag low.
  task automatic send_frame(input logic [7:0] lo,
                            input logic [7:0] hi);
    res_flag = 1'b1;
    res_byte = lo;
    tick();
    res_byte = hi;
    tick();
    res_flag = 1'b0;
    res_byte = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    res_flag = 1'b0;
    res_byte = 8'h00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: every accepted head must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL sb_unexpected: got %0h want none",
                 bus.out_data);
      end else begin
        e = sb.pop_front();
        check("sb_data", bus.out_data, e.w);
        check("sb_nan", bus.out_is_nan, e.nan);
        check("sb_inf", bus.out_is_inf, e.inf);
      end
    end
  end

  initial begin
    tbl[0] = '{8'h00, 8'h3C, 16'h3C00, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h7C, 16'h7C00, 1'b0, 1'b1};
    tbl[2] = '{8'h01, 8'h7E, 16'h7E01, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'hFC, 16'hFC00, 1'b0, 1'b1};
    tbl[4] = '{8'h01, 8'h7C, 16'h7C01, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 8'h7B, 16'h7BFF, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 16'h0000, 1'b0, 1'b0};

    do_reset();
    check("rst_level", level, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    tick();

    // Table: one frame at a time, consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      expect_word(tbl[i].word, tbl[i].nan, tbl[i].inf);
      send_frame(tbl[i].lo, tbl[i].hi);
      check("tbl_data", bus.out_data, tbl[i].word);
      check("tbl_valid", bus.out_valid, 1);
      check("tbl_level", level, 1);
      check("tbl_nan", bus.out_is_nan, tbl[i].nan);
      check("tbl_inf", bus.out_is_inf, tbl[i].inf);
      tick();
      check("tbl_drain", level, 0);
    end

    // Two queued words, popped one at a time.
    bus.out_ready = 1'b0;
    expect_word(16'h7C00, 1'b0, 1'b1);
    send_frame(8'h00, 8'h7C);
    tick();
    expect_word(16'h7E01, 1'b1, 1'b0);
    send_frame(8'h01, 8'h7E);
    check("two_level", level, 2);
    check("two_head", bus.out_data, 16'h7C00);
    check("two_inf", bus.out_is_inf, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("two_level1", level, 1);
    check("two_head1", bus.out_data, 16'h7E01);
    check("two_nan1", bus.out_is_nan, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("two_level0", level, 0);
    check("two_valid0", bus.out_valid, 0);
    check("two_nan0", bus.out_is_nan, 0);
    check("two_inf0", bus.out_is_inf, 0);
    tick();

    // Overflow: fifth word dropped, sticky flag.
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expect_word(16'(i), 1'b0, 1'b0);
      send_frame(8'(i), 8'h00);
      tick();
    end
    check("ovf_level", level, 4);
    check("ovf_flag", overflow, 1);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    check("ovf_drained", level, 0);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with a pop on the push edge.
    do_reset();
    check("rst2_ovf", overflow, 0);
    check("rst2_level", level, 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      expect_word(16'(i), 1'b0, 1'b0);
      send_frame(8'(i), 8'h00);
      tick();
    end
    check("full_level", level, 4);
    expect_word(16'h0005, 1'b0, 1'b0);
    res_flag = 1'b1;
    res_byte = 8'h05;
    tick();
    res_byte = 8'h00;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    res_flag = 1'b0;
    check("fullpop_level", level, 4);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_head", bus.out_data, 16'h0002);
    tick();
    bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    check("fullpop_empty", level, 0);

    // Aborted frame.
    res_flag = 1'b1;
    res_byte = 8'hAA;
    tick();
    res_flag = 1'b0;
    res_byte = 8'h00;
    tick();
    check("abort_ferr", frame_err, 1);
    check("abort_level", level, 0);
    tick();
    check("abort_ferr_end", frame_err, 0);
    expect_word(16'h1234, 1'b0, 1'b0);
    send_frame(8'h34, 8'h12);
    check("after_abort", bus.out_data, 16'h1234);
    check("after_abort_lv", level, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();

    // Reset at L+1, released with res_flag still high.
    res_flag = 1'b1;
    res_byte = 8'h11;
    tick();
    res_byte = 8'h22;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    res_byte = 8'h33;
    check("mid_level", level, 0);
    check("mid_valid", bus.out_valid, 0);
    check("mid_data", bus.out_data, 0);
    check("mid_ovf", overflow, 0);
    check("mid_ferr", frame_err, 0);
    tick();
    res_flag = 1'b0;
    res_byte = 8'h00;
    tick();
    check("mid_nocap", level, 0);
    check("mid_noerr", frame_err, 0);
    expect_word(16'h4321, 1'b0, 1'b0);
    send_frame(8'h21, 8'h43);
    check("mid_next", bus.out_data, 16'h4321);
    check("mid_next_lv", level, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
